rr_arbiter: RTL
===============

Name: rr_arbiter

Overview:
- Round-robin arbiter that shares one resource among n requesters; grants exactly one requester at a time.
- Built around a masked find-first-set, i.e. a rotating priority encoder.
- The grant is held until the holder signals done, drops its request, or exceeds a hold limit.
- Sits in front of any shared datapath unit (bus, encoder, memory port); grant one-hot and index feed the downstream mux select.

Parameters:
- n, 4, number of requesters; legal range n >= 2, need not be a power of two.
- max_hold, 16, maximum consecutive cycles one holder keeps the grant; 0 disables the limit.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  n  request vector; bit k = requester k wants the resource.
- done  input  1  holder releases the resource this cycle; ignored when gnt_v = 0.
- gnt  output  n  registered one-hot grant; all zero when idle.
- gnt_id  output  $clog2(n)  registered index of the granted requester.
- gnt_v  output  1  registered; 1 while any grant is active.

Behaviour:
- Reset (rst = 1 at a clock edge):
  - gnt = 0, gnt_id = 0, gnt_v = 0.
  - Internal pointer ptr = 0, hold counter = 0, state IDLE.
  - rst has priority over every other input, including mid-grant; the grant is dropped at that edge.
- State machine: two states, IDLE and BUSY.
- Pick function (combinational):
  - masked = req with bits below ptr cleared.
  - If masked != 0, winner = lowest set index of masked; else winner = lowest set index of req.
  - Wrap-around is therefore mod n, including non-power-of-two n.
- IDLE:
  - req = 0: stay IDLE, outputs stay zero.
  - Otherwise, at the edge: gnt = one-hot(winner), gnt_id = winner, gnt_v = 1, counter = 1, go to BUSY.
  - Latency: request sampled at edge k, grant visible after edge k.
- BUSY, release condition = done = 1, or req[gnt_id] = 0, or (max_hold != 0 and counter == max_hold).
  - No release: hold gnt, gnt_id and gnt_v; counter increments, saturating at max_hold.
  - Release: ptr = (gnt_id + 1) mod n.
  - Re-arbitration happens on the same edge using the updated ptr, with no dead cycle.
  - If the pick finds a winner: new grant, counter = 1, stay BUSY.
  - If req = 0: outputs go to zero and state returns to IDLE.
  - The releasing requester, if it still requests, is lowest priority, so it is re-granted only when it is alone.
- Simultaneous events:
  - done and holder dropping req together count as a single release.
  - Requests arriving mid-grant wait; there is no preemption.
- Outputs are never combinational from inputs. gnt always equals one-hot(gnt_id) when gnt_v = 1.
- Fairness: with all n requesting and each releasing after one cycle, every requester is granted exactly once per n grants.
- Counter width is $clog2(max_hold + 1), minimum 1.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE = 1'b0, ST_BUSY = 1'b1.
  - Width helper constant for the index width.
- One sub-module, rr_pick: purely combinational, parameter n.
  - Inputs: req, ptr. Outputs: winner index, any-valid flag.
  - Contains the mask plus two lowest-index priority encodes.
- rr_arbiter keeps the FSM, ptr, hold counter and output registers.

Test Plan (n = 4, max_hold = 4 unless stated):
- Reset hold: rst = 1 for 3 cycles with req = 4'b1111 -> gnt = 0000, gnt_v = 0, gnt_id = 0 throughout; first edge after rst = 0 -> gnt = 0001, gnt_id = 0.
- Rotation: req = 1111, done = 1 continuously -> gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, gnt_v stays 1.
- Hold limit: req = 0110, done = 0 -> gnt = 0010 for exactly 4 cycles, then 0100 for 4 cycles, then 0010; with max_hold = 0 -> gnt = 0010 indefinitely.
- Wrap: grant id 2 released with req = 0011 -> ptr = 3, masked empty, next gnt = 0001 on the same edge; lone requester re-grant: req = 0100 with done pulse -> gnt stays 0100, counter restarts at 1.
- Holder drops: gnt = 0010, req changes 0010 -> 1000 -> next edge gnt = 1000; req -> 0000 -> next edge gnt = 0000, gnt_v = 0, state IDLE.
- Reset mid-grant: gnt = 0100 (ptr = 3 pending), assert rst for one cycle with req = 1111 -> all outputs zero at that edge; after release, next grant is 0001 (ptr back to 0).

Source files
------------

// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and
// width helpers used by both the top level and the pick sub-module.
package rr_arbiter_pkg;

    // Arbiter FSM: IDLE when nobody holds the resource, BUSY while a grant is live.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Index width for a requester count; never narrower than one bit.
    function automatic int idx_width(input int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

    // Hold counter width able to reach max_hold; a disabled limit still keeps one bit.
    function automatic int cnt_width(input int hold_limit);
        return (hold_limit <= 0) ? 1 : $clog2(hold_limit + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: lowest requester at or above ptr wins, otherwise
// the search wraps around to the lowest requester overall.
module rr_pick
    import rr_arbiter_pkg::*;
#(
    parameter int n = 4,
    localparam int IW = idx_width(n)
) (
    input  logic [n-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          valid
);

    logic [n-1:0]  masked;
    logic [IW-1:0] win_masked;
    logic [IW-1:0] win_raw;

    // Clear every request below the pointer so the search starts at ptr.
    always_comb begin
        masked = '0;
        for (int k = 0; k < n; k++) begin
            masked[k] = req[k] && (k >= int'(ptr));
        end
    end

    // Two lowest-index encoders: one over the masked vector, one over the raw vector.
    always_comb begin
        win_masked = '0;
        win_raw    = '0;
        for (int k = n - 1; k >= 0; k--) begin
            if (masked[k]) begin
                win_masked = IW'(k);
            end
            if (req[k]) begin
                win_raw = IW'(k);
            end
        end
    end

    assign winner = (|masked) ? win_masked : win_raw;
    assign valid  = |req;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants one requester at a time and holds the grant until
// the holder signals done, drops its request, or hits the hold limit. On release
// the next winner is chosen on the same edge with the releaser at lowest priority.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int n        = 4,
    parameter int max_hold = 16,
    localparam int IW = idx_width(n)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [n-1:0]  req,
    input  logic          done,
    output logic [n-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          gnt_v
);

    localparam int CW = cnt_width(max_hold);
    localparam logic [CW-1:0] HOLD_MAX = CW'(max_hold);
    localparam logic [IW-1:0] LAST_ID  = IW'(n - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n-1:0]  gnt_d;
    logic [IW-1:0] gnt_id_d;
    logic          gnt_v_d;

    logic          holder_req;
    logic          hold_hit;
    logic          release_now;
    logic [IW-1:0] next_ptr;
    logic [IW-1:0] pick_ptr;
    logic [IW-1:0] winner;
    logic          pick_valid;
    logic [n-1:0]  win_onehot;

    // Release detection for the current holder and the pointer it leaves behind.
    always_comb begin
        holder_req  = req[gnt_id];
        hold_hit    = (max_hold != 0) && (cnt_q == HOLD_MAX);
        release_now = (state_q == ST_BUSY) && (done || !holder_req || hold_hit);
        next_ptr    = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
        pick_ptr    = release_now ? next_ptr : ptr_q;
        win_onehot  = n'(1) << winner;
    end

    rr_pick #(
        .n (n)
    ) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .winner (winner),
        .valid  (pick_valid)
    );

    // Next-state and next-output logic: grant from IDLE, hold or re-arbitrate in BUSY.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt;
        gnt_id_d = gnt_id;
        gnt_v_d  = gnt_v;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d  = ST_BUSY;
                    gnt_d    = win_onehot;
                    gnt_id_d = winner;
                    gnt_v_d  = 1'b1;
                    cnt_d    = CW'(1);
                end
            end
            ST_BUSY: begin
                if (release_now) begin
                    ptr_d = next_ptr;
                    if (pick_valid) begin
                        gnt_d    = win_onehot;
                        gnt_id_d = winner;
                        gnt_v_d  = 1'b1;
                        cnt_d    = CW'(1);
                    end else begin
                        state_d  = ST_IDLE;
                        gnt_d    = '0;
                        gnt_id_d = '0;
                        gnt_v_d  = 1'b0;
                        cnt_d    = '0;
                    end
                end else if ((max_hold != 0) && (cnt_q != HOLD_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer, counter and registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            gnt_v   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt     <= gnt_d;
            gnt_id  <= gnt_id_d;
            gnt_v   <= gnt_v_d;
        end
    end

endmodule
